// File: rtl/stopwatch_uart_formatter_pkg.sv
// Shared constants, state encoding and message length for the formatter.
// No ports; imported by the formatter top and its ASCII digit encoder.
package stopwatch_uart_formatter_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  function automatic logic [3:0] msg_len(input bit newline_en);
    return newline_en ? 4'd9 : 4'd7;
  endfunction

endpackage

// File: rtl/stopwatch_uart_formatter_bcd_to_ascii.sv
// BCD nibble to ASCII digit; non-BCD nibbles become '?'.
// Ports: bcd (4-bit in), ascii (8-bit out). Purely combinational.
module bcd_to_ascii
  import stopwatch_uart_formatter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii
);

  assign ascii = (bcd > 4'd9) ? ASCII_QMARK
                              : ASCII_0 + {4'h0, bcd};

endmodule

// File: rtl/stopwatch_uart_formatter.sv
// Snapshots stopwatch digits on send and writes "MM:SS.T"[CR LF] to a UART TX FIFO.
// Ports: clk, reset, send, 5 BCD digits, tx_full in; wr_uart, wr_data, busy, done_tick out.
module stopwatch_uart_formatter
  import stopwatch_uart_formatter_pkg::*;
#(
  parameter int NEWLINE_EN = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send,
  input  logic [3:0]            min_d1,
  input  logic [3:0]            min_d0,
  input  logic [3:0]            sec_d1,
  input  logic [3:0]            sec_d0,
  input  logic [3:0]            tenth_d,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done_tick
);

  localparam logic [3:0] LAST = msg_len(NEWLINE_EN != 0) - 4'd1;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] s_md1, s_md0, s_sd1, s_sd0, s_td;
  logic [3:0] digit;
  logic [7:0] digit_ascii;
  logic [7:0] byte_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd0;
      s_md1 <= 4'd0;
      s_md0 <= 4'd0;
      s_sd1 <= 4'd0;
      s_sd0 <= 4'd0;
      s_td  <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == IDLE && send) begin
        s_md1 <= min_d1;
        s_md0 <= min_d0;
        s_sd1 <= sec_d1;
        s_sd0 <= sec_d0;
        s_td  <= tenth_d;
      end
    end
  end

  // wr_uart is qualified combinationally by tx_full so the FIFO
  // accepts the byte in the same cycle it is presented.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_uart   = 1'b0;
    done_tick = 1'b0;
    unique case (state)
      IDLE: begin
        if (send) begin
          state_nxt = SEND;
          idx_nxt   = 4'd0;
        end
      end
      SEND: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          if (idx == LAST) state_nxt = DONE;
          else             idx_nxt   = idx + 4'd1;
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    digit = 4'd0;
    case (idx)
      4'd0:    digit = s_md1;
      4'd1:    digit = s_md0;
      4'd3:    digit = s_sd1;
      4'd4:    digit = s_sd0;
      4'd6:    digit = s_td;
      default: digit = 4'd0;
    endcase
  end

  bcd_to_ascii u_bcd (
    .bcd   (digit),
    .ascii (digit_ascii)
  );

  always_comb begin
    byte_sel = 8'h00;
    if (state == SEND) begin
      case (idx)
        4'd2:    byte_sel = ASCII_COLON;
        4'd5:    byte_sel = ASCII_DOT;
        4'd7:    byte_sel = ASCII_CR;
        4'd8:    byte_sel = ASCII_LF;
        4'd0, 4'd1, 4'd3, 4'd4, 4'd6:
                 byte_sel = digit_ascii;
        default: byte_sel = 8'h00;
      endcase
    end
  end

  assign wr_data = DATA_WIDTH'(byte_sel);

endmodule

// File: tb/tb_stopwatch_uart_formatter.sv
// Scoreboard bench for stopwatch_uart_formatter (CR LF and short variants).
// Expected bytes are queued at issue time; a negedge monitor pops on wr_uart.
module tb_stopwatch_uart_formatter;

  logic       clk = 1'b0;
  logic       reset, send1, send0, tx_full;
  logic [3:0] md1, md0, sd1, sd0, td;
  logic       wr1, busy1, done1;
  logic       wr0, busy0, done0;
  logic [7:0] data1, data0;

  int pass_cnt = 0;
  int total = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  stopwatch_uart_formatter #(.NEWLINE_EN(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .send(send1),
    .min_d1(md1), .min_d0(md0), .sec_d1(sd1), .sec_d0(sd0),
    .tenth_d(td), .tx_full(tx_full),
    .wr_uart(wr1), .wr_data(data1), .busy(busy1), .done_tick(done1)
  );

  stopwatch_uart_formatter #(.NEWLINE_EN(0), .DATA_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .send(send0),
    .min_d1(md1), .min_d0(md0), .sec_d1(sd1), .sec_d0(sd0),
    .tenth_d(td), .tx_full(1'b0),
    .wr_uart(wr0), .wr_data(data0), .busy(busy0), .done_tick(done0)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL wr1_unexpected: got byte %0h expected no write", data1);
      end else begin
        chk("byte1", int'(data1), int'(q1.pop_front()));
      end
    end
    if (wr0 === 1'b1) begin
      if (q0.size() == 0) begin
        total++;
        $display("FAIL wr0_unexpected: got byte %0h expected no write", data0);
      end else begin
        chk("byte0", int'(data0), int'(q0.pop_front()));
      end
    end
  end

  task automatic set_digits(input logic [19:0] d);
    {md1, md0, sd1, sd0, td} = d;
  endtask

  // sel=1 drives the CR LF instance, sel=0 the 7-byte instance.
  task automatic run(input bit sel, input logic [71:0] exp, input int n,
                     input int stall_len, input int resend_at,
                     input int exp_done);
    int dones;
    int donek;
    bit stall;
    for (int i = 0; i < n; i++) begin
      if (sel) q1.push_back(exp[8*(n-1-i) +: 8]);
      else     q0.push_back(exp[8*(n-1-i) +: 8]);
    end
    dones = 0;
    donek = 0;
    if (sel) send1 = 1'b1;
    else     send0 = 1'b1;
    @(posedge clk);
    #1;
    send1 = 1'b0;
    send0 = 1'b0;
    for (int k = 1; k <= exp_done + 3; k++) begin
      stall = (stall_len > 0) && (k >= 5) && (k < 5 + stall_len);
      tx_full = stall;
      if (k == resend_at) begin
        send1 = 1'b1;
        set_digits(20'h99999);
      end else begin
        send1 = 1'b0;
      end
      @(negedge clk);
      if (k == 1) chk("first_wr", int'(sel ? wr1 : wr0), 1);
      if (stall) begin
        chk("stall_wr", int'(wr1), 0);
        chk("stall_data", int'(data1), 'h39);
      end
      if (sel ? done1 : done0) begin
        dones++;
        donek = k;
      end
      if (k == exp_done + 1) chk("busy_after", int'(sel ? busy1 : busy0), 0);
      @(posedge clk);
      #1;
    end
    tx_full = 1'b0;
    send1 = 1'b0;
    chk("done_cycle", donek, exp_done);
    chk("done_count", dones, 1);
    chk("queue_empty", sel ? q1.size() : q0.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    send1 = 1'b0;
    send0 = 1'b0;
    tx_full = 1'b0;
    set_digits(20'h00000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr1", int'(wr1), 0);
    chk("rst_data1", int'(data1), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_wr0", int'(wr0), 0);
    chk("rst_busy0", int'(busy0), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    set_digits(20'h59597);
    run(1'b1, 72'h35393A35392E370D0A, 9, 0, 0, 10);

    set_digits(20'h59597);
    run(1'b1, 72'h35393A35392E370D0A, 9, 3, 0, 13);

    set_digits(20'h01234);
    run(1'b1, 72'h30313A32332E340D0A, 9, 0, 3, 10);

    set_digits(20'h123C8);
    run(1'b1, 72'h31323A333F2E380D0A, 9, 0, 0, 10);

    // Reset while idx = 5: only bytes 0..5 reach the FIFO.
    set_digits(20'h42176);
    q1.push_back(8'h34);
    q1.push_back(8'h32);
    q1.push_back(8'h3A);
    q1.push_back(8'h31);
    q1.push_back(8'h37);
    q1.push_back(8'h2E);
    send1 = 1'b1;
    @(posedge clk);
    #1;
    send1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_wr", int'(wr1), 0);
    chk("abort_busy", int'(busy1), 0);
    chk("abort_done", int'(done1), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_done", int'(done1), 0);
    end
    chk("abort_queue", q1.size(), 0);
    @(posedge clk);
    #1;
    set_digits(20'h30458);
    run(1'b1, 72'h33303A34352E380D0A, 9, 0, 0, 10);

    set_digits(20'h10000);
    run(1'b0, 72'h0031303A30302E30, 7, 0, 0, 8);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
